// File: rtl/uart_sched_pkg.sv
// Shared types and the round-robin pick function for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int MAX_REQ = 8;
    localparam int PICK_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_SENT,
        LOCK_WAIT
    } sched_state_e;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PICK_W-1:0]  ptr,
        input int                 n
    );
        rr_pick_t r;
        int       j;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (i < n && !r.found && valid[j[PICK_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[PICK_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin winner selection; force_en pins the choice to force_id during a locked message.
module uart_rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             force_en,
    input  logic [IDX_W-1:0] force_id,
    output logic [IDX_W-1:0] win_id,
    output logic             win_found
);

    logic [MAX_REQ-1:0] valid_pad;
    logic [PICK_W-1:0]  ptr_pad;
    rr_pick_t           pick;

    always_comb begin
        valid_pad              = '0;
        valid_pad[N_REQ-1:0]   = req_valid;
        ptr_pad                = '0;
        ptr_pad[IDX_W-1:0]     = rr_ptr;
        pick                   = rr_pick(valid_pad, ptr_pad, N_REQ);
        if (force_en) begin
            win_id    = force_id;
            win_found = req_valid[force_id];
        end else begin
            win_id    = IDX_W'(pick.idx);
            win_found = pick.found;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between N_REQ byte producers with round-robin
// arbitration, multi-byte grant lock and a sticky transmit/lock timeout.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    input  logic                      tx_sent,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      grant_active,
    output logic                      timeout_err,
    input  logic                      err_clr
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int TIMER_W = $clog2(TIMEOUT_CYC);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0]   LAST_ID   = IDX_W'(N_REQ - 1);

    sched_state_e       state, next_state;
    logic [IDX_W-1:0]   rr_ptr, next_ptr, win_id;
    logic [TIMER_W-1:0] timer;
    logic               lock, win_found, timer_expired;
    logic               accept, release_grant, do_timeout;

    uart_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .force_en  (state != IDLE),
        .force_id  (grant_id),
        .win_id    (win_id),
        .win_found (win_found)
    );

    assign timer_expired = (timer == TIMER_MAX);
    assign next_ptr      = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // tx_sent takes priority over an expiring timer; a pending locked byte over a lock timeout.
    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        release_grant = 1'b0;
        do_timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && !tx_busy) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT_SENT;
            WAIT_SENT: begin
                if (tx_sent) begin
                    if (!lock) begin
                        release_grant = 1'b1;
                        next_state    = IDLE;
                    end else if (win_found) begin
                        accept     = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        next_state = LOCK_WAIT;
                    end
                end else if (timer_expired) begin
                    do_timeout = 1'b1;
                    next_state = IDLE;
                end
            end
            LOCK_WAIT: begin
                if (win_found) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                end else if (timer_expired) begin
                    do_timeout = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win_id] = 1'b1;
        tx_start     = (state == ISSUE);
        grant_active = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data     <= '0;
            grant_id    <= '0;
            lock        <= 1'b0;
            rr_ptr      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                tx_data  <= req_data[win_id*DATA_W +: DATA_W];
                grant_id <= win_id;
                lock     <= !req_last[win_id];
            end
            if (do_timeout) lock <= 1'b0;
            if (do_timeout || release_grant) rr_ptr <= next_ptr;
            if (do_timeout)   timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

    // Saturating timer, restarted on each issued byte and on entry to LOCK_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == ISSUE || (state == WAIT_SENT && next_state == LOCK_WAIT)) begin
            timer <= '0;
        end else if ((state == WAIT_SENT || state == LOCK_WAIT) && !timer_expired) begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a long-timeout instance for normal traffic
// and a TIMEOUT_CYC=16 instance for the timeout scenarios, sharing all inputs.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic        tx_busy = 1'b0;
    logic        tx_sent = 1'b0;
    logic        err_clr = 1'b0;

    logic [3:0]  ready_a, ready_t;
    logic [7:0]  tx_data_a, tx_data_t;
    logic        tx_start_a, tx_start_t;
    logic [1:0]  grant_id_a, grant_id_t;
    logic        grant_active_a, grant_active_t;
    logic        timeout_err_a, timeout_err_t;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYC(65536)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(ready_a), .tx_data(tx_data_a),
        .tx_start(tx_start_a), .tx_busy(tx_busy), .tx_sent(tx_sent),
        .grant_id(grant_id_a), .grant_active(grant_active_a),
        .timeout_err(timeout_err_a), .err_clr(err_clr)
    );

    uart_tx_sched #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut_t (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(ready_t), .tx_data(tx_data_t),
        .tx_start(tx_start_t), .tx_busy(tx_busy), .tx_sent(tx_sent),
        .grant_id(grant_id_t), .grant_active(grant_active_t),
        .timeout_err(timeout_err_t), .err_clr(err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
        tx_busy = 1'b0; tx_sent = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        tick(); #1;
        checks++; if (tx_data_a !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data_a); end
        checks++; if (tx_start_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start_a); end
        checks++; if (ready_a !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0000", ready_a); end
        checks++; if (grant_id_a !== 2'd0) begin failures++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id_a); end
        checks++; if (grant_active_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_grant_active: got %b expected 0", grant_active_a); end
        checks++; if (timeout_err_a !== 1'b0 || timeout_err_t !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout_err: got %b/%b expected 0/0", timeout_err_a, timeout_err_t); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_byte();
        do_reset();
        tx_busy = 1'b1; req_valid = 4'b0100; req_data[23:16] = 8'h41; req_last = 4'b0100;
        #1;
        checks++; if (ready_a !== 4'b0000) begin failures++; $display("[TB] FAIL single_busy_block: got %b expected 0000", ready_a); end
        tick(); tx_busy = 1'b0; #1;
        checks++; if (ready_a !== 4'b0100) begin failures++; $display("[TB] FAIL single_ready: got %b expected 0100", ready_a); end
        tick(); req_valid = '0; #1;
        checks++; if (tx_start_a !== 1'b1) begin failures++; $display("[TB] FAIL single_start: got %b expected 1", tx_start_a); end
        checks++; if (tx_data_a !== 8'h41) begin failures++; $display("[TB] FAIL single_data: got %h expected 41", tx_data_a); end
        checks++; if (grant_id_a !== 2'd2) begin failures++; $display("[TB] FAIL single_grant_id: got %0d expected 2", grant_id_a); end
        tick(); #1;
        checks++; if (tx_start_a !== 1'b0) begin failures++; $display("[TB] FAIL single_start_pulse: got %b expected 0", tx_start_a); end
        repeat (19) tick();
        tx_sent = 1'b1; #1;
        checks++; if (grant_active_a !== 1'b1) begin failures++; $display("[TB] FAIL single_active_wait: got %b expected 1", grant_active_a); end
        tick(); tx_sent = 1'b0; #1;
        checks++; if (grant_active_a !== 1'b0) begin failures++; $display("[TB] FAIL single_idle: got %b expected 0", grant_active_a); end
        checks++; if (dut.rr_ptr !== 2'd3) begin failures++; $display("[TB] FAIL single_rr_ptr: got %0d expected 3", dut.rr_ptr); end
        checks++; if (tx_data_a !== 8'h41) begin failures++; $display("[TB] FAIL single_data_hold: got %h expected 41", tx_data_a); end
    endtask

    task automatic test_round_robin();
        int         exp_order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_ready;
        logic [7:0] exp_data;
        int         starts;
        do_reset();
        req_valid = 4'hF; req_last = 4'hF; req_data = 32'h13121110;
        for (int g = 0; g < 5; g++) begin
            exp_ready = 4'b0001 << exp_order[g];
            exp_data  = 8'h10 + 8'(exp_order[g]);
            #1;
            checks++; if (ready_a !== exp_ready) begin failures++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", g, ready_a, exp_ready); end
            starts = 0;
            tick(); #1; starts += int'(tx_start_a);
            checks++; if (tx_data_a !== exp_data) begin failures++; $display("[TB] FAIL rr_data%0d: got %h expected %h", g, tx_data_a, exp_data); end
            tick(); tx_sent = 1'b1; #1; starts += int'(tx_start_a);
            checks++; if (ready_a !== 4'b0000) begin failures++; $display("[TB] FAIL rr_no_accept%0d: got %b expected 0000", g, ready_a); end
            tick(); tx_sent = 1'b0; #1; starts += int'(tx_start_a);
            checks++; if (starts != 1) begin failures++; $display("[TB] FAIL rr_starts%0d: got %0d expected 1", g, starts); end
        end
    endtask

    task automatic test_lock();
        do_reset();
        req_valid = 4'b0010; req_data[15:8] = 8'h48; req_last = 4'b0000;
        #1;
        checks++; if (ready_a !== 4'b0010) begin failures++; $display("[TB] FAIL lock_first: got %b expected 0010", ready_a); end
        tick(); req_valid = 4'b0011; req_data[15:8] = 8'h49; req_data[7:0] = 8'h55; req_last = 4'b0001; #1;
        checks++; if (tx_data_a !== 8'h48) begin failures++; $display("[TB] FAIL lock_data0: got %h expected 48", tx_data_a); end
        tick(); #1;
        checks++; if (ready_a !== 4'b0000) begin failures++; $display("[TB] FAIL lock_stall: got %b expected 0000", ready_a); end
        tick(); tx_sent = 1'b1; #1;
        checks++; if (ready_a !== 4'b0010) begin failures++; $display("[TB] FAIL lock_second: got %b expected 0010", ready_a); end
        tick(); tx_sent = 1'b0; req_data[15:8] = 8'h0A; req_last = 4'b0011; #1;
        checks++; if (tx_start_a !== 1'b1 || tx_data_a !== 8'h49) begin failures++; $display("[TB] FAIL lock_data1: got start=%b data=%h expected 1/49", tx_start_a, tx_data_a); end
        tick(); tx_sent = 1'b1; #1;
        checks++; if (ready_a !== 4'b0010) begin failures++; $display("[TB] FAIL lock_third: got %b expected 0010", ready_a); end
        tick(); tx_sent = 1'b0; req_valid = 4'b0001; #1;
        checks++; if (tx_data_a !== 8'h0A || grant_id_a !== 2'd1) begin failures++; $display("[TB] FAIL lock_data2: got data=%h id=%0d expected 0a/1", tx_data_a, grant_id_a); end
        tick(); tx_sent = 1'b1; #1;
        checks++; if (ready_a !== 4'b0000) begin failures++; $display("[TB] FAIL lock_release: got %b expected 0000", ready_a); end
        tick(); tx_sent = 1'b0; #1;
        checks++; if (ready_a !== 4'b0001) begin failures++; $display("[TB] FAIL lock_next_req0: got %b expected 0001", ready_a); end
        tick(); #1;
        checks++; if (tx_data_a !== 8'h55 || grant_id_a !== 2'd0) begin failures++; $display("[TB] FAIL lock_req0_data: got data=%h id=%0d expected 55/0", tx_data_a, grant_id_a); end
    endtask

    task automatic test_lock_starvation();
        int stall_bad;
        do_reset();
        req_valid = 4'b1000; req_data[31:24] = 8'h33; req_last = 4'b0000;
        #1;
        checks++; if (ready_t !== 4'b1000) begin failures++; $display("[TB] FAIL starve_grant3: got %b expected 1000", ready_t); end
        tick(); req_valid = '0;
        tick(); tx_sent = 1'b1;
        tick(); tx_sent = 1'b0; req_valid = 4'b0001; req_data[7:0] = 8'h01; req_last = 4'b0001;
        stall_bad = 0;
        for (int k = 0; k < 15; k++) begin
            #1; if (ready_t !== 4'b0000) stall_bad++;
            tick();
        end
        #1;
        checks++; if (stall_bad != 0) begin failures++; $display("[TB] FAIL starve_stall: got %0d accepts expected 0", stall_bad); end
        checks++; if (timeout_err_t !== 1'b0 || grant_active_t !== 1'b1) begin failures++; $display("[TB] FAIL starve_pre_timeout: got err=%b active=%b expected 0/1", timeout_err_t, grant_active_t); end
        tick(); #1;
        checks++; if (timeout_err_t !== 1'b1) begin failures++; $display("[TB] FAIL starve_err: got %b expected 1", timeout_err_t); end
        checks++; if (grant_active_t !== 1'b0) begin failures++; $display("[TB] FAIL starve_idle: got %b expected 0", grant_active_t); end
        checks++; if (dut_t.rr_ptr !== 2'd0 || dut_t.lock !== 1'b0) begin failures++; $display("[TB] FAIL starve_ptr_lock: got ptr=%0d lock=%b expected 0/0", dut_t.rr_ptr, dut_t.lock); end
        checks++; if (ready_t !== 4'b0001) begin failures++; $display("[TB] FAIL starve_next: got %b expected 0001", ready_t); end
        tick(); req_valid = '0; err_clr = 1'b1; #1;
        checks++; if (timeout_err_t !== 1'b1) begin failures++; $display("[TB] FAIL starve_err_held: got %b expected 1", timeout_err_t); end
        tick(); err_clr = 1'b0; #1;
        checks++; if (timeout_err_t !== 1'b0) begin failures++; $display("[TB] FAIL starve_err_clr: got %b expected 0", timeout_err_t); end
    endtask

    task automatic test_lost_sent();
        do_reset();
        req_valid = 4'b0011; req_data[7:0] = 8'h77; req_data[15:8] = 8'h88; req_last = 4'b0011;
        #1;
        checks++; if (ready_t !== 4'b0001) begin failures++; $display("[TB] FAIL lost_first: got %b expected 0001", ready_t); end
        tick(); #1;
        checks++; if (tx_start_t !== 1'b1 || tx_data_t !== 8'h77) begin failures++; $display("[TB] FAIL lost_start: got start=%b data=%h expected 1/77", tx_start_t, tx_data_t); end
        tick();
        repeat (15) tick();
        #1;
        checks++; if (grant_active_t !== 1'b1 || timeout_err_t !== 1'b0) begin failures++; $display("[TB] FAIL lost_pre_timeout: got active=%b err=%b expected 1/0", grant_active_t, timeout_err_t); end
        tick(); #1;
        checks++; if (timeout_err_t !== 1'b1 || grant_active_t !== 1'b0) begin failures++; $display("[TB] FAIL lost_timeout: got err=%b active=%b expected 1/0", timeout_err_t, grant_active_t); end
        checks++; if (ready_t !== 4'b0010) begin failures++; $display("[TB] FAIL lost_next_grant: got %b expected 0010", ready_t); end
        tick(); req_valid = '0; #1;
        checks++; if (tx_data_t !== 8'h88 || grant_id_t !== 2'd1) begin failures++; $display("[TB] FAIL lost_next_data: got data=%h id=%0d expected 88/1", tx_data_t, grant_id_t); end
        tick(); tx_sent = 1'b1;
        tick(); tx_sent = 1'b0;
        tick(); tx_sent = 1'b1;
        tick(); tx_sent = 1'b0; #1;
        checks++; if (grant_active_t !== 1'b0 || tx_start_t !== 1'b0) begin failures++; $display("[TB] FAIL lost_stray_sent: got active=%b start=%b expected 0/0", grant_active_t, tx_start_t); end
    endtask

    task automatic test_reset_mid();
        int starts;
        do_reset();
        req_valid = 4'b0100; req_data[23:16] = 8'h5A; req_last = 4'b0000;
        tick(); req_valid = '0;
        tick(); tick(); #1;
        checks++; if (grant_active_a !== 1'b1 || tx_data_a !== 8'h5A) begin failures++; $display("[TB] FAIL rstmid_pre: got active=%b data=%h expected 1/5a", grant_active_a, tx_data_a); end
        rst_n = 1'b0; #1;
        checks++; if (grant_active_a !== 1'b0 || tx_start_a !== 1'b0 || ready_a !== 4'b0000) begin failures++; $display("[TB] FAIL rstmid_ctrl: got active=%b start=%b ready=%b expected 0/0/0000", grant_active_a, tx_start_a, ready_a); end
        checks++; if (tx_data_a !== 8'h00 || grant_id_a !== 2'd0 || timeout_err_a !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_data: got data=%h id=%0d err=%b expected 00/0/0", tx_data_a, grant_id_a, timeout_err_a); end
        checks++; if (dut.rr_ptr !== 2'd0 || dut.lock !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_ptr_lock: got ptr=%0d lock=%b expected 0/0", dut.rr_ptr, dut.lock); end
        tick(); rst_n = 1'b1;
        starts = 0;
        repeat (8) begin tick(); starts += int'(tx_start_a); end
        checks++; if (starts != 0) begin failures++; $display("[TB] FAIL rstmid_no_start: got %0d expected 0", starts); end
        req_valid = 4'b0010; req_data[15:8] = 8'h66; req_last = 4'b0010; #1;
        checks++; if (ready_a !== 4'b0010) begin failures++; $display("[TB] FAIL rstmid_new_grant: got %b expected 0010", ready_a); end
        tick(); req_valid = '0; #1;
        checks++; if (tx_start_a !== 1'b1 || tx_data_a !== 8'h66) begin failures++; $display("[TB] FAIL rstmid_new_start: got start=%b data=%h expected 1/66", tx_start_a, tx_data_a); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_lock();
        test_lock_starvation();
        test_lost_sent();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares one UART transmitter between `N_REQ` byte producers, e.g. CPU MMIO, debug monitor and exception logger. It arbitrates round-robin and can hold a grant for multi-byte messages. It sequences the transmitter with a start pulse per byte and waits for the transmitter's byte-sent indication. It sits between the producers and the UART transmit block, and exposes a sticky timeout error for the CSR block.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, byte width
- `TIMEOUT_CYC`, 65536, max cycles between `tx_start` and `tx_sent`, or spent waiting in lock

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  byte offered by requester i
- `req_data`  in  N_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
- `req_last`  in  N_REQ  offered byte ends the message; 0 requests grant lock
- `req_ready`  out  N_REQ  one-hot; byte of requester i accepted this cycle
- `tx_data`  out  DATA_W  registered byte to the transmitter
- `tx_start`  out  1  one-cycle pulse; transmitter loads `tx_data`
- `tx_busy`  in  1  transmitter busy
- `tx_sent`  in  1  one-cycle pulse; byte fully shifted out
- `grant_id`  out  $clog2(N_REQ)  current/last granted requester
- `grant_active`  out  1  a message is in progress
- `timeout_err`  out  1  sticky; set on timeout
- `err_clr`  in  1  clears `timeout_err`

## Operation
- States: `IDLE`, `ISSUE`, `WAIT_SENT`, `LOCK_WAIT`.
- **IDLE**
  - If any `req_valid` and `!tx_busy`, the winner w is the first valid requester at or after `rr_ptr`, wrapping modulo `N_REQ`.
  - `req_ready[w]`=1 combinationally in that cycle, `tx_data`<=`req_data[w]`, `grant_id`<=w, `lock`<=`!req_last[w]`, next state `ISSUE`.
- **ISSUE**
  - `tx_start`=1 for exactly this cycle, timer<=0, next state `WAIT_SENT`.
- **WAIT_SENT**
  - The timer increments every cycle.
  - On `tx_sent` with `lock`=1:
    - if `req_valid[grant_id]`, accept that byte as in IDLE (the `tx_busy` check is skipped) and go to `ISSUE`;
    - otherwise timer<=0 and go to `LOCK_WAIT`.
  - On `tx_sent` with `lock`=0: `rr_ptr`<=`grant_id`+1 (mod `N_REQ`), go to `IDLE`.
  - If the timer reaches `TIMEOUT_CYC`-1 without `tx_sent`: `timeout_err`<=1, `lock`<=0, `rr_ptr`<=`grant_id`+1, go to `IDLE`.
- **LOCK_WAIT**
  - Only `grant_id` can be accepted; other requesters are stalled.
  - On `req_valid[grant_id]`, accept and go to `ISSUE`.
  - On timeout: same as the `WAIT_SENT` timeout.
- `grant_active`=1 in every state except IDLE.
- `tx_sent` in IDLE or ISSUE is ignored.
- `err_clr` and a simultaneous timeout: set wins.
- Requesters must not make `req_valid` depend on `req_ready`. Data is held stable while valid and not accepted.

## Timing
- Reset values:
  - state `IDLE`, `rr_ptr`=0, `lock`=0;
  - `tx_data`=0, `tx_start`=0, `req_ready`=0;
  - `grant_id`=0, `grant_active`=0, `timeout_err`=0.
- If accept is at cycle T:
  - `tx_start`=1 at T+1;
  - `tx_data` is valid from T+1 and holds until the next accept.
- Back-to-back locked bytes: the next accept is in the same cycle as `tx_sent`, and its `tx_start` follows 1 cycle later.
- A reset mid-message drops the byte, the lock and the pointer immediately, with no `tx_start` glitch.
- The timer is $clog2(`TIMEOUT_CYC`) bits wide and saturates; it never wraps.

## Structure
- Package `uart_sched_pkg`:
  - `sched_state_e` enum (4 states);
  - `rr_pick` function (valid vector, pointer → index plus found flag).
- Sub-module `uart_rr_arbiter`:
  - combinational winner selection from `req_valid` and `rr_ptr`, with an optional mask forcing `grant_id` during lock;
  - `rr_ptr` stays in the top-level FSM.

## Test plan
- **Single byte:** requester 2 sends 0x41 with last=1, `tx_sent` 20 cycles after `tx_start`.
  - `req_ready[2]` at T, `tx_start` at T+1 with `tx_data`=0x41.
  - IDLE after `tx_sent`, `rr_ptr`=3.
- **Round-robin:** all 4 requesters valid with last=1.
  - Grants in order 0,1,2,3,0 starting from reset.
  - Exactly one `tx_start` per `tx_sent`.
- **Lock:** requester 1 sends 0x48, 0x49 (last=0), then 0x0A (last=1) while requester 0 is also valid.
  - Three consecutive grants to 1; requester 0 is granted next.
- **Lock starvation:** requester 3 sends last=0 and then drops valid, with `TIMEOUT_CYC`=16.
  - `timeout_err`=1 sixteen cycles into `LOCK_WAIT`, state IDLE, `rr_ptr`=0.
  - `err_clr` pulse clears the error.
- **Lost `tx_sent`:** no pulse after `tx_start`.
  - Timeout after `TIMEOUT_CYC` cycles, next requester granted.
  - A stray `tx_sent` arriving later in IDLE is ignored.
- **Reset mid-WAIT_SENT:** assert `rst_n`=0 in WAIT_SENT.
  - All outputs take their reset values asynchronously.
  - No `tx_start` appears after release until a new `req_valid`.
